// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared period counter, per-channel shadow/active duty registers.
// Optional PWM_SOFTSTART_EN ramps each active duty by one LSB per period toward its shadow value.

module pwm_multi_ch #(
    parameter int unsigned SYS_CLK_FREQ = 100_000_000,
    parameter int          CH           = 4,
    parameter int          RES_BITS     = 9
) (
    input  logic                   clk,
    input  logic                   reset_p,
    input  logic                   enable,
    input  logic [13:0]            pwm_freq,
    input  logic [CH*RES_BITS-1:0] duty,
    input  logic                   duty_load,
    output logic [CH-1:0]          pwm_out,
    output logic                   period_start,
    output logic                   load_pending
);

    localparam int CNT_W = $clog2(SYS_CLK_FREQ + 1);

    typedef logic [RES_BITS-1:0] duty_t;
    typedef logic [CNT_W-1:0]    cnt_t;

    localparam duty_t STEP_MAX = '1;

    logic [13:0]   freq_q, freq_d;
    logic [31:0]   denom;
    cnt_t          div;
    cnt_t          tick_q, tick_d;
    duty_t         step_q, step_d;
    logic          first_q, first_d;
    logic          load_pending_q, load_pending_d;
    logic [CH-1:0] pwm_out_q, pwm_out_d;
    duty_t         duty_ch  [CH];
    duty_t         shadow_q [CH];
    duty_t         shadow_d [CH];
    duty_t         active_q [CH];
    duty_t         active_d [CH];

    logic run;
    logic tick;
    logic boundary;

    // Clocks per step; a zero quotient (frequency too high) is clamped to one clock.
    always_comb begin
        denom = 32'(freq_q) << RES_BITS;
        div   = cnt_t'(1);
        if (denom != '0 && (SYS_CLK_FREQ / denom) != 32'd0) begin
            div = cnt_t'(SYS_CLK_FREQ / denom);
        end
    end

    assign run      = enable && (freq_q != '0);
    assign tick     = run && (tick_q >= div - cnt_t'(1));
    assign boundary = tick && (first_q || step_q == STEP_MAX);

    // Counters, frequency sampling and output compare.
    // NOTE: every variable written in an always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        tick_d    = '0;
        step_d    = '0;
        first_d   = 1'b1;
        freq_d    = freq_q;
        pwm_out_d = '0;

        if (run) begin
            first_d = first_q && !tick;
            if (tick) begin
                // The first tick after start-up opens the period at step 0 instead of advancing.
                step_d = first_q ? '0 : step_q + duty_t'(1);
            end else begin
                tick_d = tick_q + cnt_t'(1);
                step_d = step_q;
            end
        end

        // While stopped no period is running, so tracking the input cannot truncate one.
        if (!run || boundary) begin
            freq_d = pwm_freq;
        end

        for (int i = 0; i < CH; i++) begin
            pwm_out_d[i] = run && (step_q < active_q[i]);
        end
    end

    // Shadow capture and shadow-to-active transfer at the period boundary.
    always_comb begin
        load_pending_d = load_pending_q;
        for (int i = 0; i < CH; i++) begin
            duty_ch[i]  = duty[i*RES_BITS +: RES_BITS];
            shadow_d[i] = shadow_q[i];
            active_d[i] = active_q[i];
        end

        if (duty_load) begin
            load_pending_d = 1'b1;
            for (int i = 0; i < CH; i++) begin
                shadow_d[i] = duty_ch[i];
            end
        end

`ifdef PWM_SOFTSTART_EN
        if (boundary && load_pending_d) begin
            load_pending_d = 1'b0;
            for (int i = 0; i < CH; i++) begin
                if (active_q[i] < shadow_d[i]) begin
                    active_d[i] = active_q[i] + duty_t'(1);
                end else if (active_q[i] > shadow_d[i]) begin
                    active_d[i] = active_q[i] - duty_t'(1);
                end
                if (active_d[i] != shadow_d[i]) begin
                    load_pending_d = 1'b1;
                end
            end
        end
`else
        // A load coinciding with the boundary lands in active directly and never shows as pending.
        if (boundary && load_pending_d) begin
            load_pending_d = 1'b0;
            for (int i = 0; i < CH; i++) begin
                active_d[i] = shadow_d[i];
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only; the comb blocks above use blocking.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            freq_q         <= '0;
            tick_q         <= '0;
            step_q         <= '0;
            first_q        <= 1'b1;
            load_pending_q <= 1'b0;
            pwm_out_q      <= '0;
            // NOTE: the duty arrays are plain flops, not RAM, so they clear with the async reset.
            for (int i = 0; i < CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            freq_q         <= freq_d;
            tick_q         <= tick_d;
            step_q         <= step_d;
            first_q        <= first_d;
            load_pending_q <= load_pending_d;
            pwm_out_q      <= pwm_out_d;
            for (int i = 0; i < CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = boundary;
    assign load_pending = load_pending_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: 1.024 MHz clock, 4 channels, 9-bit duty, 100 Hz -> div 20, 10240-clock period.
// Build with PWM_SOFTSTART_EN defined to run the soft-start ramp scenario instead of the default set.

module tb_pwm_multi_ch;

    localparam int CH  = 4;
    localparam int RES = 9;

    logic              clk = 1'b0;
    logic              reset_p;
    logic              enable;
    logic [13:0]       pwm_freq;
    logic [CH*RES-1:0] duty;
    logic              duty_load;
    logic [CH-1:0]     pwm_out;
    logic              period_start;
    logic              load_pending;

    int checks = 0;
    int errors = 0;

    int meas_len;
    int meas_pend;
    int meas_high [CH];

    always #5 clk = ~clk;

    pwm_multi_ch #(
        .SYS_CLK_FREQ(1_024_000),
        .CH          (CH),
        .RES_BITS    (RES)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .enable      (enable),
        .pwm_freq    (pwm_freq),
        .duty        (duty),
        .duty_load   (duty_load),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .load_pending(load_pending)
    );

    function automatic logic [CH*RES-1:0] pack4(input int d0, input int d1, input int d2, input int d3);
        return {RES'(d3), RES'(d2), RES'(d1), RES'(d0)};
    endfunction

    // One-cycle duty_load strobe, driven from a falling edge.
    task automatic load_duty(input logic [CH*RES-1:0] val);
        duty      = val;
        duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
    endtask

    // Counts falling edges until period_start is seen; -1 if it never comes.
    task automatic wait_start(output int edges);
        edges = -1;
        for (int k = 1; k <= 20000; k++) begin
            @(negedge clk);
            if (period_start) begin
                edges = k;
                break;
            end
        end
    endtask

    // Starting on a period_start cycle, samples one full period up to the next period_start.
    task automatic run_period(input int load_at, input logic [CH*RES-1:0] load_val,
                              input int freq_at, input logic [13:0] freq_val);
        meas_len  = 0;
        meas_pend = 0;
        for (int c = 0; c < CH; c++) meas_high[c] = 0;
        for (int k = 0; k < 20000; k++) begin
            if (k == load_at) begin
                duty      = load_val;
                duty_load = 1'b1;
            end else begin
                duty_load = 1'b0;
            end
            if (k == freq_at) pwm_freq = freq_val;
            @(negedge clk);
            meas_len++;
            for (int c = 0; c < CH; c++) if (pwm_out[c]) meas_high[c]++;
            if (load_pending) meas_pend++;
            if (period_start) break;
        end
        duty_load = 1'b0;
    endtask

    task automatic test_reset();
        reset_p   = 1'b1;
        enable    = 1'b0;
        pwm_freq  = 14'd100;
        duty      = '0;
        duty_load = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_out !== 4'b0000) begin
            errors++; $display("FAIL reset_pwm_out: got %b expected 0000", pwm_out);
        end
        checks++;
        if (period_start !== 1'b0 || load_pending !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got start=%b pend=%b expected 0 0", period_start, load_pending);
        end
        reset_p = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (pwm_out !== 4'b0000 || period_start !== 1'b0) begin
            errors++; $display("FAIL disabled_idle: got out=%b start=%b expected 0000 0", pwm_out, period_start);
        end
    endtask

    task automatic test_basic();
        int e;
        int exp_h [CH];
        exp_h = '{2560, 0, 10220, 5120};
        load_duty(pack4(128, 0, 511, 256));
        checks++;
        if (load_pending !== 1'b1) begin
            errors++; $display("FAIL basic_pending_set: got %b expected 1", load_pending);
        end
        enable = 1'b1;
        wait_start(e);
        // The boundary is the rising edge following the sample that shows period_start.
        checks++;
        if (e + 1 !== 20) begin
            errors++; $display("FAIL basic_first_boundary: got %0d clocks expected 20", e + 1);
        end
        run_period(-1, '0, -1, '0);
        checks++;
        if (meas_len !== 10240) begin
            errors++; $display("FAIL basic_period: got %0d expected 10240", meas_len);
        end
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (meas_high[c] !== exp_h[c]) begin
                errors++; $display("FAIL basic_high_ch%0d: got %0d expected %0d", c, meas_high[c], exp_h[c]);
            end
        end
        checks++;
        if (meas_pend !== 0) begin
            errors++; $display("FAIL basic_pending_cleared: got %0d pending cycles expected 0", meas_pend);
        end
    endtask

    task automatic test_midload();
        run_period(1000, pack4(384, 0, 511, 256), -1, '0);
        checks++;
        if (meas_high[0] !== 2560) begin
            errors++; $display("FAIL midload_current_high: got %0d expected 2560", meas_high[0]);
        end
        checks++;
        if (meas_pend !== 9240) begin
            errors++; $display("FAIL midload_pending_cycles: got %0d expected 9240", meas_pend);
        end
        run_period(-1, '0, -1, '0);
        checks++;
        if (meas_high[0] !== 7680) begin
            errors++; $display("FAIL midload_next_high: got %0d expected 7680", meas_high[0]);
        end
        checks++;
        if (meas_pend !== 0 || meas_len !== 10240) begin
            errors++; $display("FAIL midload_next_period: got pend=%0d len=%0d expected 0 10240", meas_pend, meas_len);
        end
    endtask

    task automatic test_bypass();
        run_period(0, pack4(64, 0, 511, 256), -1, '0);
        checks++;
        if (meas_high[0] !== 1280) begin
            errors++; $display("FAIL bypass_high: got %0d expected 1280", meas_high[0]);
        end
        checks++;
        if (meas_pend !== 0) begin
            errors++; $display("FAIL bypass_pending: got %0d pending cycles expected 0", meas_pend);
        end
    endtask

    task automatic test_freq_change();
        int exp_h [CH];
        exp_h = '{640, 0, 5110, 2560};
        run_period(-1, '0, 3000, 14'd200);
        checks++;
        if (meas_len !== 10240) begin
            errors++; $display("FAIL freq_current_period: got %0d expected 10240", meas_len);
        end
        run_period(-1, '0, -1, '0);
        checks++;
        if (meas_len !== 5120) begin
            errors++; $display("FAIL freq_next_period: got %0d expected 5120", meas_len);
        end
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (meas_high[c] !== exp_h[c]) begin
                errors++; $display("FAIL freq_high_ch%0d: got %0d expected %0d", c, meas_high[c], exp_h[c]);
            end
        end
    endtask

    task automatic test_enable();
        int e;
        int starts;
        repeat (100) @(negedge clk);
        checks++;
        if (pwm_out !== 4'b1101) begin
            errors++; $display("FAIL enable_running: got %b expected 1101", pwm_out);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (pwm_out !== 4'b0000) begin
            errors++; $display("FAIL enable_drop: got %b expected 0000", pwm_out);
        end
        load_duty(pack4(32, 0, 511, 256));
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (period_start || pwm_out != 4'b0000) starts++;
        end
        checks++;
        if (starts !== 0 || load_pending !== 1'b1) begin
            errors++; $display("FAIL enable_hold: got activity=%0d pend=%b expected 0 1", starts, load_pending);
        end
        enable = 1'b1;
        wait_start(e);
        checks++;
        if (e + 1 !== 10) begin
            errors++; $display("FAIL enable_restart: got %0d clocks expected 10", e + 1);
        end
        @(negedge clk);
        checks++;
        if (load_pending !== 1'b0) begin
            errors++; $display("FAIL enable_transfer: got pend=%b expected 0", load_pending);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        int bad;
        int exp_h [CH];
        exp_h = '{0, 0, 0, 0};
        repeat (200) @(negedge clk);
        load_duty(pack4(100, 0, 511, 256));
        pwm_freq = 14'd0;
        repeat (50) @(negedge clk);
        checks++;
        if (pwm_out[2] !== 1'b1 || load_pending !== 1'b1) begin
            errors++; $display("FAIL resetmid_before: got out2=%b pend=%b expected 1 1", pwm_out[2], load_pending);
        end
        #2 reset_p = 1'b1;
        #1;
        checks++;
        if (pwm_out !== 4'b0000 || period_start !== 1'b0 || load_pending !== 1'b0) begin
            errors++; $display("FAIL resetmid_async: got out=%b start=%b pend=%b expected 0000 0 0",
                               pwm_out, period_start, load_pending);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (period_start || pwm_out != 4'b0000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL resetmid_silent: got %0d active samples expected 0", bad);
        end
        enable   = 1'b0;
        pwm_freq = 14'd100;
        @(negedge clk);
        reset_p = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_start(e);
        checks++;
        if (e + 1 !== 20) begin
            errors++; $display("FAIL resetmid_first_boundary: got %0d clocks expected 20", e + 1);
        end
        run_period(-1, '0, -1, '0);
        checks++;
        if (meas_len !== 10240 || meas_pend !== 0) begin
            errors++; $display("FAIL resetmid_period: got len=%0d pend=%0d expected 10240 0", meas_len, meas_pend);
        end
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (meas_high[c] !== exp_h[c]) begin
                errors++; $display("FAIL resetmid_high_ch%0d: got %0d expected %0d", c, meas_high[c], exp_h[c]);
            end
        end
    endtask

    task automatic test_softstart();
        int e;
        load_duty(pack4(4, 0, 0, 0));
        enable = 1'b1;
        wait_start(e);
        checks++;
        if (e + 1 !== 20) begin
            errors++; $display("FAIL soft_first_boundary: got %0d clocks expected 20", e + 1);
        end
        for (int p = 1; p <= 4; p++) begin
            run_period(-1, '0, -1, '0);
            checks++;
            if (meas_high[0] !== 20 * p) begin
                errors++; $display("FAIL soft_high_p%0d: got %0d expected %0d", p, meas_high[0], 20 * p);
            end
            checks++;
            if (meas_pend !== ((p < 4) ? 10240 : 0)) begin
                errors++; $display("FAIL soft_pending_p%0d: got %0d expected %0d", p, meas_pend, (p < 4) ? 10240 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef PWM_SOFTSTART_EN
        test_softstart();
`else
        test_basic();
        test_midload();
        test_bypass();
        test_freq_change();
        test_enable();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
Parametrised multi-channel PWM generator. It succeeds the single-channel 512-step block with configurable resolution and channel count. All channels share one period counter. Each channel has a shadow duty register that transfers to its active register only at a period boundary, which gives glitch-free duty updates. The block sits between control FSMs (fan speed, LED dimming, servo) and output pins.

Parameters:
SYS_CLK_FREQ, 100_000_000, system clock frequency in Hz (Basys 100 MHz, Cora 125 MHz)
CH, 4, number of PWM channels (1..16)
RES_BITS, 9, duty resolution in bits; the period has 2^RES_BITS steps

Ports:
clk  in  1  system clock, rising edge
reset_p  in  1  asynchronous reset, active-high
enable  in  1  1 = run; 0 = counters held at 0, outputs low
pwm_freq  in  14  PWM frequency in Hz; 0 = stopped
duty  in  CH*RES_BITS  packed duties; channel i occupies bits [i*RES_BITS +: RES_BITS]
duty_load  in  1  one-cycle strobe; captures all of duty into the shadow registers
pwm_out  out  CH  PWM outputs, registered
period_start  out  1  one-cycle pulse at each period boundary
load_pending  out  1  high from the duty_load capture until the shadow-to-active transfer

Behaviour:
- Reset (async, reset_p=1): pwm_out=0, period_start=0, load_pending=0. Tick counter, step counter, shadow and active duties = 0.
- Divider: div = SYS_CLK_FREQ / (freq_r << RES_BITS), integer division, combinational from the registered freq_r. If the result is 0, div is forced to 1.
- freq_r samples pwm_freq at reset release and at every period boundary. A frequency change never truncates the current period.
- Tick counter runs 0..div-1 and emits tick when it wraps.
- Step counter advances by 1 per tick and wraps from 2^RES_BITS-1 to 0.
- Period boundary: the clock edge where step wraps to 0, plus the first tick after enable rises. On that cycle:
  - period_start=1;
  - if load_pending, shadow copies to active and load_pending clears.
- Output: pwm_out[i] <= (step < active[i]) on every clock; it lags step by one clock.
  - High time = active[i]*div clocks per period.
  - duty=0 gives constant low.
  - duty=2^RES_BITS-1 gives high for all but one step.
- duty_load=1: shadow <= duty and load_pending <= 1 on the same edge.
  - If it coincides with a period boundary, the new duty is written straight to active at that boundary (bypass) and load_pending stays 0.
  - Repeated loads before a boundary: the last one wins.
- freq_r=0 or enable=0: tick and step are held at 0, pwm_out=0, period_start=0. Shadow and load_pending are retained.
- enable deassert mid-period: outputs go low on the next edge. Re-enable restarts at step 0.
- Reset mid-period: all state clears immediately, and a pending load is discarded.

Optional Feature:
PWM_SOFTSTART_EN
- Defined: at each period boundary, each active[i] moves at most 1 LSB toward shadow[i].
  - load_pending stays high until every channel's active equals its shadow.
  - Bypass on a coincident load does not apply; the new value only sets the target.
- Undefined: active is loaded in full at the boundary, as described in Behaviour.

Test Plan:
Bench overrides: SYS_CLK_FREQ=1_024_000, CH=4, RES_BITS=9, pwm_freq=100, giving div=20 and a period of 10240 clocks.
1. Reset, then duty_load with ch0=128, ch1=0, ch2=511, ch3=256, enable=1 -> after the first boundary: ch0 high 2560 clocks, ch1 always low, ch2 high 10220 clocks, ch3 high 5120 clocks; period_start every 10240 clocks.
2. Mid-period, load ch0=384 -> current period keeps 2560 high; load_pending=1 until the next period_start; the following period is high 7680 clocks.
3. duty_load asserted on the period_start cycle with ch0=64 -> that period is already high 1280 clocks; load_pending never rises.
4. Change pwm_freq 100->200 mid-period -> current period completes at 10240 clocks; the next is 5120 clocks (div=10).
5. pwm_freq=0, then reset_p pulse mid-period -> all pwm_out=0 and period_start silent. After reset release with freq=100, the first boundary pulse arrives 20 clocks after enable.
6. With PWM_SOFTSTART_EN defined, load ch0 from 0 to 4 -> high times per period are 20, 40, 60, 80 clocks; load_pending clears at the 4th boundary.
